// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI byte engine.
package spi_pkg;
    localparam int SPI_BYTE_BITS = 8;
    typedef enum logic [1:0] {IDLE, SHIFT, TAIL, POLL} spi_eng_state_t;
endpackage

// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if: client-side byte stream, RX FIFO and control signals of the SPI byte engine.
interface spi_byte_engine_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [7:0]                    TxData;
    logic                          TxValid;
    logic                          TxLast;
    logic                          TxReady;
    logic [7:0]                    RxData;
    logic                          RxValid;
    logic                          RxPop;
    logic [$clog2(FIFO_DEPTH):0]   RxCount;
    logic                          RxOverflow;
    logic                          Abort;
    logic                          Busy;
    modport master (
        output TxData, TxValid, TxLast, RxPop, Abort,
        input  TxReady, RxData, RxValid, RxCount, RxOverflow, Busy
    );
    modport slave (
        input  TxData, TxValid, TxLast, RxPop, Abort,
        output TxReady, RxData, RxValid, RxCount, RxOverflow, Busy
    );
endinterface

// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: synchronous byte FIFO with flush; pushes while full are dropped.
module spi_rx_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        SClk,
    input  logic                        nReset,
    input  logic                        clear,
    input  logic                        push,
    input  logic                        pop,
    input  logic [7:0]                  din,
    output logic [7:0]                  dout,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = count == CW'(FIFO_DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = empty ? 8'h00 : mem[rp];
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (clear) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge SClk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/spi_byte_engine.sv
// spi_byte_engine: byte-stream SPI master front end feeding SPIMux, MISO captured into an RX FIFO.
// Defining SPI_READY_POLL_EN adds device ready-bit polling after each TxLast byte.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             SClk,
    input  logic             nReset,
    spi_byte_engine_if.slave bus,
    output logic             SPISel,
    output logic             SPIDo,
    output logic             SPIClkRunning,
    input  logic             SPIDi
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SHIFT = SHIFT;
    localparam logic [1:0] ST_TAIL  = TAIL;
    localparam logic [1:0] ST_POLL  = POLL;
    localparam logic [2:0] TOP_BIT  = 3'(SPI_BYTE_BITS - 1);
    logic [1:0] state;
    logic [7:0] sh;
    logic [2:0] cnt, rx_cnt;
    logic [6:0] rx_sh;
    logic       last, samp, ovf, fifo_full, fifo_empty;
    logic       shifting, take, rx_push, poll_run;
`ifdef SPI_READY_POLL_EN
    logic psamp, pdone;
    assign poll_run = state == ST_POLL && !pdone;
`else
    assign poll_run = 1'b0;
`endif
    assign shifting       = state == ST_SHIFT;
    assign bus.TxReady    = nReset && (state == ST_IDLE || (shifting && cnt == '0 && !last));
    assign take           = bus.TxValid && bus.TxReady && !bus.Abort;
    // MISO lags the driven bit by one cycle, so a sample is taken on the cycle after each shift
    assign rx_push        = samp && rx_cnt == TOP_BIT;
    assign SPIDo          = shifting ? sh[7] : state == ST_POLL;
    assign SPIClkRunning  = shifting || poll_run;
    assign bus.Busy       = state != ST_IDLE;
    assign bus.RxValid    = !fifo_empty;
    assign bus.RxOverflow = ovf;
    spi_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .SClk  (SClk),
        .nReset(nReset),
        .clear (bus.Abort),
        .push  (rx_push),
        .pop   (bus.RxPop),
        .din   ({rx_sh, SPIDi}),
        .dout  (bus.RxData),
        .count (bus.RxCount),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state  <= ST_IDLE;
            sh     <= '0;
            cnt    <= '0;
            last   <= 1'b0;
            SPISel <= 1'b0;
            samp   <= 1'b0;
            rx_sh  <= '0;
            rx_cnt <= '0;
            ovf    <= 1'b0;
`ifdef SPI_READY_POLL_EN
            psamp  <= 1'b0;
            pdone  <= 1'b0;
`endif
        end else if (bus.Abort) begin
            state  <= ST_IDLE;
            SPISel <= 1'b0;
            samp   <= 1'b0;
            rx_cnt <= '0;
            ovf    <= 1'b0;
`ifdef SPI_READY_POLL_EN
            psamp  <= 1'b0;
            pdone  <= 1'b0;
`endif
        end else begin
            samp <= shifting;
`ifdef SPI_READY_POLL_EN
            psamp <= poll_run;
`endif
            if (samp) begin
                rx_sh  <= {rx_sh[5:0], SPIDi};
                rx_cnt <= rx_cnt + 3'd1;
            end
            if (rx_push && fifo_full) ovf <= 1'b1;
            if (take) begin
                state  <= ST_SHIFT;
                sh     <= bus.TxData;
                cnt    <= TOP_BIT;
                last   <= bus.TxLast;
                SPISel <= 1'b1;
            end else if (shifting) begin
                sh  <= {sh[6:0], 1'b0};
                cnt <= cnt - 3'd1;
                if (cnt == '0) state <= ST_TAIL;
            end else if (state == ST_TAIL) begin
`ifdef SPI_READY_POLL_EN
                state <= last ? ST_POLL : ST_IDLE;
                pdone <= 1'b0;
`else
                state <= ST_IDLE;
                if (last) SPISel <= 1'b0;
`endif
            end
`ifdef SPI_READY_POLL_EN
            else if (state == ST_POLL) begin
                if (pdone) begin
                    state  <= ST_IDLE;
                    SPISel <= 1'b0;
                end else if (psamp && SPIDi) pdone <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: randomized bursts checked cycle by cycle against a transaction-timeline model.
module tb_spi_byte_engine;
    localparam int DEPTH = 4;
    logic SClk = 0, nReset = 0, SPIDi = 0;
    wire  SPISel, SPIDo, SPIClkRunning;
    spi_byte_engine_if #(.FIFO_DEPTH(DEPTH)) bus();
    spi_byte_engine #(.FIFO_DEPTH(DEPTH)) dut (
        .SClk(SClk), .nReset(nReset), .bus(bus), .SPISel(SPISel),
        .SPIDo(SPIDo), .SPIClkRunning(SPIClkRunning), .SPIDi(SPIDi)
    );
    always #5 SClk = ~SClk;

    typedef struct {
        bit sel, clk, dout, rdy, busy, mi, tv, tl, push;
        logic [7:0] td, pd;
    } ent_t;
    ent_t       sq[$];
    ent_t       cur;
    logic [7:0] mq[$];
    logic [7:0] bq[$], rq[$];
    bit         e_ovf, sel_hold, chk, blast;
    int         poll_k, nvec, nerr;
    int         sel_cnt, clk_cnt, run;
    int         runs[$];
    logic [7:0] do_rec;

    task automatic cmp(input string n, input logic [7:0] a, input logic [7:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge SClk) if (chk) begin
        cmp("SPISel", 8'(SPISel), 8'(cur.sel));
        cmp("SPIClkRunning", 8'(SPIClkRunning), 8'(cur.clk));
        if (cur.clk) cmp("SPIDo", 8'(SPIDo), 8'(cur.dout));
        cmp("TxReady", 8'(bus.TxReady), 8'(cur.rdy));
        cmp("Busy", 8'(bus.Busy), 8'(cur.busy));
        cmp("RxCount", 8'(bus.RxCount), 8'(mq.size()));
        cmp("RxValid", 8'(bus.RxValid), 8'(mq.size() > 0));
        cmp("RxOverflow", 8'(bus.RxOverflow), 8'(e_ovf));
        if (mq.size() > 0) cmp("RxData", bus.RxData, mq[0]);
    end

    always @(negedge SClk) begin
        if (SPISel) sel_cnt++;
        if (SPIClkRunning) begin
            clk_cnt++;
            do_rec = {do_rec[6:0], SPIDo};
            run++;
        end else if (run > 0) begin
            runs.push_back(run);
            run = 0;
        end
    end

    function automatic bit rbit(input int m);
        logic [7:0] r = rq[m / 8];
        return r[7 - m % 8];
    endfunction

    task automatic build();
        int   n = bq.size();
        ent_t e;
        for (int j = 0; j < 8 * n; j++) begin
            int i = j / 8;
            logic [7:0] b = bq[i];
            e = '{default: 0};
            e.sel  = 1; e.clk = 1; e.busy = 1;
            e.dout = b[7 - j % 8];
            e.rdy  = (j % 8 == 7) && !(i == n - 1 && blast);
            e.mi   = (j == 0) ? 1'($urandom) : rbit(j - 1);
            if (j % 8 == 7 && i < n - 1) begin
                e.tv = 1; e.td = bq[i + 1]; e.tl = blast && (i + 1 == n - 1);
            end
            if (j % 8 == 0 && i > 0) begin
                e.push = 1; e.pd = rq[i - 1];
            end
            sq.push_back(e);
        end
        e = '{default: 0};
        e.sel = 1; e.busy = 1; e.mi = rbit(8 * n - 1); e.push = 1; e.pd = rq[n - 1];
        sq.push_back(e);
`ifdef SPI_READY_POLL_EN
        if (blast) begin
            e = '{default: 0};
            e.sel = 1; e.clk = 1; e.dout = 1; e.busy = 1; e.mi = 1;
            sq.push_back(e);
            e.mi = 0;
            for (int k = 0; k < poll_k; k++) sq.push_back(e);
            e.mi = 1;
            sq.push_back(e);
            e.clk = 0; e.mi = 1'($urandom);
            sq.push_back(e);
        end
`endif
        sel_hold = !blast;
    endtask

    task automatic cyc(input bit start, input bit ab, input bit pop);
        bit idle, full, popok;
        idle = sq.size() == 0;
        if (!idle) cur = sq.pop_front();
        else begin
            cur = '{default: 0};
            cur.sel = sel_hold; cur.rdy = 1; cur.mi = 1'($urandom);
            if (start) begin
                cur.tv = 1; cur.td = bq[0]; cur.tl = blast && bq.size() == 1;
            end
        end
        SPIDi = cur.mi; bus.TxValid = cur.tv; bus.TxData = cur.td; bus.TxLast = cur.tl;
        bus.RxPop = pop; bus.Abort = ab;
        @(negedge SClk);
        @(posedge SClk);
        if (ab) begin
            sq.delete(); mq.delete(); e_ovf = 0; sel_hold = 0;
        end else begin
            full  = mq.size() == DEPTH;
            popok = pop && mq.size() > 0;
            if (popok) mq.delete(0);
            if (cur.push) begin
                if (full) e_ovf = 1;
                else mq.push_back(cur.pd);
            end
            if (idle && start) build();
        end
        #1;
    endtask

    task automatic xfer(input int abort_at, input int pop_at, input bit rpop);
        cyc(1, abort_at == 0, pop_at == 0);
        for (int i = 1; i < 1000 && sq.size() > 0; i++)
            cyc(0, i == abort_at, i == pop_at || (rpop && $urandom_range(0, 3) == 0));
    endtask

    task automatic setb(input int n, input logic [7:0] b0, input logic [7:0] r0, input bit l);
        bq.delete(); rq.delete(); blast = l;
        for (int i = 0; i < n; i++) begin
            bq.push_back(b0 + 8'(i * 8'h22));
            rq.push_back(r0 + 8'(i * 8'h11));
        end
    endtask

    initial begin
        int s0, c0, r0;
        logic [7:0] ex [4];
        bus.TxValid = 0; bus.TxData = 0; bus.TxLast = 0; bus.RxPop = 0; bus.Abort = 0;
        poll_k = 5;
        #12;
        cmp("rst_SPISel", 8'(SPISel), 8'h0);
        cmp("rst_SPIDo", 8'(SPIDo), 8'h0);
        cmp("rst_SPIClkRunning", 8'(SPIClkRunning), 8'h0);
        cmp("rst_TxReady", 8'(bus.TxReady), 8'h0);
        cmp("rst_Busy", 8'(bus.Busy), 8'h0);
        cmp("rst_RxValid", 8'(bus.RxValid), 8'h0);
        cmp("rst_RxCount", 8'(bus.RxCount), 8'h0);
        cmp("rst_RxOverflow", 8'(bus.RxOverflow), 8'h0);
        cmp("rst_RxData", bus.RxData, 8'h00);
        @(negedge SClk) nReset = 1;
        @(posedge SClk) #1;
        cur = '{default: 0}; chk = 1;
        cmp("idle_TxReady", 8'(bus.TxReady), 8'h1);

        // single byte 0xA5, device answers 0x3C
        bq = '{8'hA5}; rq = '{8'h3C}; blast = 1;
        s0 = sel_cnt; c0 = clk_cnt;
        xfer(-1, -1, 0);
`ifdef SPI_READY_POLL_EN
        cmp("poll_sel_cycles", 8'(sel_cnt - s0), 8'd17);
        cmp("poll_clk_cycles", 8'(clk_cnt - c0), 8'd15);
        cmp("poll_Busy", 8'(bus.Busy), 8'h0);
`else
        cmp("a5_sel_cycles", 8'(sel_cnt - s0), 8'd9);
        cmp("a5_clk_cycles", 8'(clk_cnt - c0), 8'd8);
        cmp("a5_SPIDo_seq", do_rec, 8'hA5);
`endif
        cmp("a5_SPISel_after", 8'(SPISel), 8'h0);
        cmp("a5_RxData", bus.RxData, 8'h3C);
        cmp("a5_RxCount", 8'(bus.RxCount), 8'd1);
        cyc(0, 0, 1);

        // back-to-back burst of four bytes
        bq = '{8'h12, 8'h34, 8'h56, 8'h78}; rq = '{8'hC1, 8'hD2, 8'hE3, 8'hF4}; blast = 1;
        ex = '{8'hC1, 8'hD2, 8'hE3, 8'hF4};
        r0 = runs.size();
        xfer(-1, -1, 0);
        cmp("b2b_clk_run", 8'(runs[r0]), 8'd32);
        cmp("b2b_RxCount", 8'(bus.RxCount), 8'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("b2b_rx_order", bus.RxData, ex[i]);
            cyc(0, 0, 1);
        end

        // five bytes into a four-entry FIFO
        setb(5, 8'h01, 8'h11, 1);
        xfer(-1, -1, 0);
        cmp("ovf_RxCount", 8'(bus.RxCount), 8'd4);
        cmp("ovf_RxOverflow", 8'(bus.RxOverflow), 8'h1);
        cmp("ovf_head", bus.RxData, 8'h11);
        cyc(0, 1, 0);
        cmp("abort_clr_RxCount", 8'(bus.RxCount), 8'd0);
        cmp("abort_clr_RxOverflow", 8'(bus.RxOverflow), 8'h0);

        // abort while bit 3 is on the wire, then a clean byte
        bq = '{8'h5A}; rq = '{8'h00}; blast = 1;
        xfer(5, -1, 0);
        cmp("abort_SPISel", 8'(SPISel), 8'h0);
        cmp("abort_RxCount", 8'(bus.RxCount), 8'd0);
        cmp("abort_Busy", 8'(bus.Busy), 8'h0);
        bq = '{8'h96}; rq = '{8'h69}; blast = 1;
        xfer(-1, -1, 0);
        cmp("post_abort_RxData", bus.RxData, 8'h69);
        cmp("post_abort_RxCount", 8'(bus.RxCount), 8'd1);

        // pop coinciding with push at count 2
        bq = '{8'h01, 8'h02}; rq = '{8'hAA, 8'hBB}; blast = 1;
        xfer(-1, 17, 0);
        cmp("pp_RxCount", 8'(bus.RxCount), 8'd2);
        cmp("pp_head0", bus.RxData, 8'hAA);
        cyc(0, 0, 1);
        cmp("pp_head1", bus.RxData, 8'hBB);
        cyc(0, 0, 1);
        cmp("pp_empty", 8'(bus.RxCount), 8'd0);

        // Abort beats TxValid in IDLE
        bq = '{8'hFF}; rq = '{8'h00}; blast = 1;
        cyc(1, 1, 0);
        cmp("prio_Busy", 8'(bus.Busy), 8'h0);
        cmp("prio_SPISel", 8'(SPISel), 8'h0);

        repeat (250) begin
            int n = $urandom_range(1, 5);
            bq.delete(); rq.delete();
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                rq.push_back(8'($urandom));
            end
            blast  = $urandom_range(0, 2) != 0;
            poll_k = $urandom_range(0, 6);
            xfer(($urandom_range(0, 5) == 0) ? $urandom_range(1, 8 * n + 2) : -1, -1, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) cyc(0, $urandom_range(0, 30) == 0, $urandom_range(0, 3) == 0);
        end
        chk = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
